key_expand_serial: RTL and testbench
====================================

// Module: key_expand_serial
// PURPOSE
//  Byte-serial AES-128 key schedule. Consumes the 16-byte cipher key one byte per clock,
//  MSB byte first, from the parallel-to-serial key stage. Emits all 176 round-key bytes
//  (rounds 0..10, 16 bytes each) one byte per clock to the byte-serial round datapath.
//  Holds a 16-byte sliding window, one sbox, and an rcon generator; no 1408-bit storage.
// PARAMETERS
//  NR      10   number of expanded rounds after round 0 (fixed 10 for AES-128)
//  NB_KEY  16   key bytes per round
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous active-low reset (0 = reset)
//  key_valid  in   1  key_byte is valid this cycle
//  key_byte   in   8  cipher key byte, byte 0 (key[127:120]) first
//  key_ready  out  1  block accepts key_byte this cycle
//  rk_valid   out  1  rk_byte is valid
//  rk_byte    out  8  round-key byte
//  rk_ready   in   1  downstream accepts rk_byte
//  rk_round   out  4  round index (0..10) of rk_byte
//  rk_last    out  1  rk_byte is byte 15 of round 10
//  busy       out  1  high in LOAD or EXPAND
//  done       out  1  one-cycle pulse after the last byte is accepted
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, window=0, byte/round counters=0, rcon=8'h01.
//    Outputs: rk_valid=0, rk_byte=0, rk_round=0, rk_last=0, busy=0, done=0.
//    Reset mid-operation aborts immediately; no partial output resumes.
//  - Output register: adv = ~rk_valid | rk_ready. rk_valid drops only on rk_ready with
//    nothing new produced. rk_byte/rk_round/rk_last stay stable while rk_valid & ~rk_ready.
//  - key_ready = (state==IDLE | state==LOAD) & adv.
//  - IDLE: key_valid & key_ready -> LOAD. The accepted byte counts as byte 0.
//  - LOAD: each accepted key byte shifts into window[15] and is forwarded to the output
//    register next cycle as round 0 (latency 1). After byte 15 is accepted -> EXPAND,
//    with j=0 and r=1.
//  - EXPAND, when adv: compute and emit one new byte w[i]. The new byte shifts into the
//    window, advances j, and wraps j 15->0 with r+1. W[0] is the oldest byte, w[i-16].
//      j==0     : W[0] ^ sbox(W[13]) ^ rcon
//      j==1,2   : W[0] ^ sbox(W[13])
//      j==3     : W[0] ^ sbox(W[9])
//      j>=4     : W[0] ^ W[12]
//    rcon is updated by xtime when j wraps: 01,02,04,08,10,20,40,80,1B,36.
//    When adv is low, the window, j, r and rcon are frozen (full stall).
//  - After r=10, j=15 is loaded into the output register: set rk_last=1, go to DRAIN.
//    DRAIN waits for rk_ready, then pulses done=1 for one cycle -> IDLE, with rcon=01.
//  - key_valid outside IDLE/LOAD is ignored (key_ready=0).
//  - Throughput: 1 byte/clk with no backpressure. Key first byte in -> round-key byte 175
//    out in 176 cycles + 1 register latency.
//  - rk_round width: 4 bits; values 11..15 never occur.
// STRUCTURE
//  - Shared package aes_pkg: localparams NR=10, NB_KEY=16, RCON_INIT=8'h01, and the
//    state encoding (IDLE, LOAD, EXPAND, DRAIN); function xtime(byte).
//  - Sub-module aes_sbox: combinational 8-bit in / 8-bit out lookup. One instance, shared
//    by the datapath stage.
//  - Reuse the existing 8-bit shift_reg_8 for window bytes, or use an equivalent array.
//    Every register uses async active-low rst.
// TESTING
//  1 FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 ->
//    round 1 bytes a0fafe17 88542cb1 23a33939 2a6c7605; round 10 bytes
//    d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rk_last with byte a6; done 1 cycle later.
//  2 All-zero key -> round 1 = 62636363 62636363 62636363 62636363;
//    round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
//  3 Random rk_ready (50%) with the A.1 key -> identical 176-byte sequence.
//    rk_byte is stable while stalled; no byte is dropped or duplicated.
//  4 rst asserted when rk_round=5 -> all outputs 0 within the same cycle.
//    A new A.1 key then reproduces vector 1 exactly.
//  5 key_valid held high during EXPAND -> key_ready=0 and the output sequence is
//    unaffected. A back-to-back second key after done produces correct rounds.
//  6 key bytes with gaps (key_valid toggling) -> round-0 bytes echo the key in order.
//    Expansion starts only after byte 15 is accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, controller state encoding and the GF(2^8) doubling
// helper used by the serial key expander.
package aes_pkg;

    localparam int unsigned NR        = 10;
    localparam int unsigned NB_KEY    = 16;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExpand,
        StDrain
    } state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box. One row of the table per line, entry 0x00 leftmost.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/key_expand_serial.sv
// Byte-serial AES-128 key schedule: accepts the key one byte per clock and streams all 176
// round-key bytes through a single output register using a 16-byte sliding window.
module key_expand_serial
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       key_ready,
    output logic       rk_valid,
    output logic [7:0] rk_byte,
    input  logic       rk_ready,
    output logic [3:0] rk_round,
    output logic       rk_last,
    output logic       busy,
    output logic       done
);

    state_e     state_q, state_d;
    logic [7:0] win_q [NB_KEY];
    logic [3:0] j_q, j_d;
    logic [3:0] r_q, r_d;
    logic [7:0] rcon_q, rcon_d;
    logic       rk_valid_q, rk_valid_d;
    logic [7:0] rk_byte_q, rk_byte_d;
    logic [3:0] rk_round_q, rk_round_d;
    logic       rk_last_q, rk_last_d;
    logic       done_q, done_d;

    logic       adv;
    logic       shift_en;
    logic [7:0] shift_byte;
    logic [7:0] sbox_a, sbox_y;
    logic [7:0] new_byte;

    assign adv       = ~rk_valid_q | rk_ready;
    assign key_ready = ((state_q == StIdle) || (state_q == StLoad)) && adv;
    assign busy      = (state_q == StLoad) || (state_q == StExpand);

    // W[13] is the rotated byte of the previous word for j=0..2; W[9] wraps it for j=3.
    assign sbox_a = (j_q == 4'd3) ? win_q[9] : win_q[13];

    aes_sbox u_sbox (
        .a (sbox_a),
        .y (sbox_y)
    );

    always_comb begin
        if (j_q == 4'd0) begin
            new_byte = win_q[0] ^ sbox_y ^ rcon_q;
        end else if (j_q < 4'd4) begin
            new_byte = win_q[0] ^ sbox_y;
        end else begin
            new_byte = win_q[0] ^ win_q[12];
        end
    end

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        r_d        = r_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        rk_byte_d  = rk_byte_q;
        rk_round_d = rk_round_q;
        rk_last_d  = rk_last_q;
        done_d     = 1'b0;
        shift_en   = 1'b0;
        shift_byte = key_byte;

        unique case (state_q)
            StIdle, StLoad: begin
                if (adv) begin
                    rk_valid_d = 1'b0;
                end
                if (key_valid && key_ready) begin
                    shift_en   = 1'b1;
                    rk_valid_d = 1'b1;
                    rk_byte_d  = key_byte;
                    rk_round_d = '0;
                    rk_last_d  = 1'b0;
                    if (j_q == 4'(NB_KEY - 1)) begin
                        state_d = StExpand;
                        j_d     = '0;
                        r_d     = 4'd1;
                    end else begin
                        state_d = StLoad;
                        j_d     = j_q + 4'd1;
                    end
                end
            end
            StExpand: begin
                if (adv) begin
                    shift_en   = 1'b1;
                    shift_byte = new_byte;
                    rk_valid_d = 1'b1;
                    rk_byte_d  = new_byte;
                    rk_round_d = r_q;
                    rk_last_d  = (r_q == 4'(NR)) && (j_q == 4'(NB_KEY - 1));
                    if (j_q == 4'(NB_KEY - 1)) begin
                        j_d    = '0;
                        rcon_d = xtime(rcon_q);
                        if (r_q == 4'(NR)) begin
                            state_d = StDrain;
                        end else begin
                            r_d = r_q + 4'd1;
                        end
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end
            end
            StDrain: begin
                if (rk_ready) begin
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                    rcon_d     = RCON_INIT;
                    r_d        = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            j_q        <= '0;
            r_q        <= '0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            rk_byte_q  <= '0;
            rk_round_q <= '0;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            r_q        <= r_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            rk_byte_q  <= rk_byte_d;
            rk_round_q <= rk_round_d;
            rk_last_q  <= rk_last_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB_KEY; i++) begin
                win_q[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < NB_KEY - 1; i++) begin
                win_q[i] <= win_q[i+1];
            end
            win_q[NB_KEY-1] <= shift_byte;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_byte  = rk_byte_q;
    assign rk_round = rk_round_q;
    assign rk_last  = rk_last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_key_expand_serial.sv
// Scoreboard bench for key_expand_serial: a word-level FIPS-197 key schedule model feeds an
// expectation queue that a negedge monitor drains on every output handshake.
module tb_key_expand_serial;

    logic       clk, rst;
    logic       key_valid, key_ready;
    logic [7:0] key_byte;
    logic       rk_valid, rk_ready, rk_last, busy, done;
    logic [7:0] rk_byte;
    logic [3:0] rk_round;

    key_expand_serial dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_byte  (key_byte),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_byte   (rk_byte),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy),
        .done      (done)
    );

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int          total, bad;
    logic [12:0] sb_q[$];
    logic [12:0] mon_exp, prev_out;
    logic [7:0]  tsbox  [256];
    logic [7:0]  ref_rk [176];
    logic [7:0]  dut_rk [176];
    int          cap_idx, last_idx;
    bit          exp_done_next, done_seen, last_seen, stall_prev, rand_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] y;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            end
            y = inv;
            tsbox[x] = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                       ^ {y[3:0], y[7:4]} ^ 8'h63;
        end
    endfunction

    function automatic void build_ref(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tsbox[t[31:24]], tsbox[t[23:16]], tsbox[t[15:8]], tsbox[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 176; i++) ref_rk[i] = w[i/4][31-8*(i%4) -: 8];
    endfunction

    function automatic logic [127:0] dut_round(input int r);
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++) v[127-8*k -: 8] = dut_rk[16*r+k];
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (exp_done_next) begin
                chk("done_pulse", done, 1'b1);
                done_seen     = 1'b1;
                exp_done_next = 1'b0;
            end else if (done) begin
                chk("spurious_done", done, 1'b0);
            end
            if (stall_prev) begin
                chk("stall_hold", {rk_valid, rk_last, rk_round, rk_byte}, {1'b1, prev_out});
            end
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_byte: got %0h with nothing expected", rk_byte);
                end else begin
                    mon_exp = sb_q.pop_front();
                    chk("rk_out", {rk_last, rk_round, rk_byte}, mon_exp);
                end
                if (cap_idx < 176) dut_rk[cap_idx] = rk_byte;
                if (rk_last) begin
                    last_idx      = cap_idx;
                    last_seen     = 1'b1;
                    exp_done_next = 1'b1;
                end
                cap_idx++;
            end
            stall_prev = rk_valid && !rk_ready;
            prev_out   = {rk_last, rk_round, rk_byte};
        end
    end

    task automatic run_key(input logic [127:0] key, input bit gaps, input bit hold,
                           input int abort_round);
        bit acc;
        int guard;
        build_ref(key);
        for (int i = 0; i < 176; i++) begin
            sb_q.push_back({(i == 175) ? 1'b1 : 1'b0, 4'(i / 16), ref_rk[i]});
        end
        cap_idx   = 0;
        last_idx  = -1;
        last_seen = 1'b0;
        done_seen = 1'b0;
        @(posedge clk);
        #2;
        for (int b = 0; b < 16; b++) begin
            if (gaps) begin
                key_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    if (b > 0) chk("load_gap", {busy, rk_valid && (rk_round != 4'd0)}, 2'b10);
                    @(posedge clk);
                    #2;
                end
            end
            key_valid = 1'b1;
            key_byte  = key[127-8*b -: 8];
            acc       = 1'b0;
            guard     = 0;
            while (!acc && guard < 1000) begin
                @(negedge clk);
                acc = key_ready;
                @(posedge clk);
                #2;
                guard++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL key_accept: byte %0d got no key_ready, required 1", b);
            end
        end
        key_valid = hold;
        key_byte  = 8'($urandom);
        guard     = 0;
        while (!done_seen && guard < 3000) begin
            if (hold && !last_seen) chk("key_ready_low", key_ready, 1'b0);
            if (hold && last_seen) key_valid = 1'b0;
            if (abort_round > 0 && rk_valid && rk_round == 4'(abort_round)) begin
                rst = 1'b0;
                #1;
                chk("abort_zero", {rk_valid, rk_byte, rk_round, rk_last, busy, done}, '0);
                sb_q.delete();
                stall_prev    = 1'b0;
                exp_done_next = 1'b0;
                key_valid     = 1'b0;
                #4 rst = 1'b1;
                return;
            end
            @(posedge clk);
            #2;
            guard++;
        end
        key_valid = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: done got 0, required 1 within 3000 cycles");
        end
        chk("queue_drained", sb_q.size(), 0);
        chk("byte_count", cap_idx, 176);
        chk("last_index", last_idx, 175);
    endtask

    initial begin
        logic [127:0] k;
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        key_valid     = 1'b0;
        key_byte      = 8'h00;
        rand_ready    = 1'b0;
        stall_prev    = 1'b0;
        exp_done_next = 1'b0;
        build_sbox();
        #12;
        chk("reset_outputs", {rk_valid, rk_byte, rk_round, rk_last, busy, done}, '0);
        #11 rst = 1'b1;

        run_key(KEY_A1, 1'b0, 1'b0, 0);
        chk("a1_round1", dut_round(1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("a1_round10", dut_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("a1_last_byte", dut_rk[175], 8'ha6);

        run_key('0, 1'b0, 1'b0, 0);
        chk("zero_round1", dut_round(1), 128'h62636363626363636263636362636363);
        chk("zero_round10", dut_round(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        rand_ready = 1'b1;
        run_key(KEY_A1, 1'b0, 1'b0, 0);
        rand_ready = 1'b0;
        chk("bp_round10", dut_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(KEY_A1, 1'b0, 1'b0, 5);
        run_key(KEY_A1, 1'b0, 1'b0, 0);
        chk("post_abort_round1", dut_round(1), 128'ha0fafe1788542cb123a339392a6c7605);
        chk("post_abort_round10", dut_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 0);
        run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, 0);

        rand_ready = 1'b1;
        k = {$urandom, $urandom, $urandom, $urandom};
        run_key(k, 1'b1, 1'b0, 0);
        chk("gap_round0_echo", dut_round(0), k);
        run_key(KEY_A1, 1'b1, 1'b0, 0);
        chk("gap_a1_round0", dut_round(0), KEY_A1);
        rand_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
